// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

   typedef enum logic {IDLE, CLEAR} rf_clr_state_t;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_PC_OFFSET = 8;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks clr_addr from 0 to LAST, one register per cycle,
// holding busy high for the whole walk.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int LAST   = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

   rf_clr_state_t     state;
   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == LAST_A) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = busy;
   assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered reads, two write ports, PC
// redirect and bulk clear. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_REGS  = 16,
   parameter int ADDR_W    = $clog2(NUM_REGS),
   parameter int NUM_RD    = 3,
   parameter int PC_IDX    = NUM_REGS - 1,
   parameter int PC_OFFSET = DEF_PC_OFFSET
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic [DATA_W-1:0]        pc_in,
   output logic                     pc_wr_valid,
   output logic [DATA_W-1:0]        pc_wr_data,
   output logic                     wr_conflict,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] regs [PC_IDX];
   logic [DATA_W-1:0] rd_next [NUM_RD];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr0_st, wr1_st, wr0_pc, wr1_pc, same_addr;

   regfile_clear_seq #(
      .ADDR_W (ADDR_W),
      .LAST   (PC_IDX - 1)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Addresses above PC_IDX fall through every decode and are ignored.
   assign wr0_st    = wr0_en && !busy && (wr0_addr < PC_A);
   assign wr1_st    = wr1_en && !busy && (wr1_addr < PC_A);
   assign wr0_pc    = wr0_en && !busy && (wr0_addr == PC_A);
   assign wr1_pc    = wr1_en && !busy && (wr1_addr == PC_A);
   assign same_addr = (wr0_addr == wr1_addr) && (wr0_addr <= PC_A);

   always_comb begin : read_mux
      logic [ADDR_W-1:0] a;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         a          = rd_addr[k*ADDR_W +: ADDR_W];
         rd_next[k] = '0;
         if (a == PC_A)
            rd_next[k] = pc_in + DATA_W'(PC_OFFSET);
         else if (a < PC_A)
            rd_next[k] = regs[a];
`ifdef REGFILE_BYPASS_EN
         if (wr0_st && (wr0_addr == a))
            rd_next[k] = wr0_data;
         if (wr1_st && (wr1_addr == a))
            rd_next[k] = wr1_data;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (rd_en[k])
               rd_data[k*DATA_W +: DATA_W] <= rd_next[k];
         end
      end
   end

   // wr1 is issued second so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < PC_IDX; i++)
            regs[i] <= '0;
      end else if (clr_we) begin
         regs[clr_addr] <= '0;
      end else begin
         if (wr0_st)
            regs[wr0_addr] <= wr0_data;
         if (wr1_st)
            regs[wr1_addr] <= wr1_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_wr_valid <= 1'b0;
         pc_wr_data  <= '0;
         wr_conflict <= 1'b0;
      end else begin
         pc_wr_valid <= wr0_pc || wr1_pc;
         if (wr1_pc)
            pc_wr_data <= wr1_data;
         else if (wr0_pc)
            pc_wr_data <= wr0_data;
         wr_conflict <= wr0_en && wr1_en && !busy && same_addr;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp; read expectations are queued at issue time
// and compared one cycle later.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rd_en;
   logic [11:0] rd_addr;
   logic [95:0] rd_data;
   logic        wr0_en, wr1_en;
   logic [3:0]  wr0_addr, wr1_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [31:0] pc_in;
   logic        pc_wr_valid;
   logic [31:0] pc_wr_data;
   logic        wr_conflict;
   logic        clr_req;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl [15];
   logic [31:0] exp_q [$];
   int          port_q [$];
   logic [31:0] last_rd [3];

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr0_en      (wr0_en),
      .wr0_addr    (wr0_addr),
      .wr0_data    (wr0_data),
      .wr1_en      (wr1_en),
      .wr1_addr    (wr1_addr),
      .wr1_data    (wr1_data),
      .pc_in       (pc_in),
      .pc_wr_valid (pc_wr_valid),
      .pc_wr_data  (pc_wr_data),
      .wr_conflict (wr_conflict),
      .clr_req     (clr_req),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      rd_en   = '0;
      wr0_en  = 1'b0;
      wr1_en  = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic wr(input int port, input int a, input logic [31:0] d);
      if (port == 0) begin
         wr0_en = 1'b1; wr0_addr = a[3:0]; wr0_data = d;
      end else begin
         wr1_en = 1'b1; wr1_addr = a[3:0]; wr1_data = d;
      end
   endtask

   // Call after staging any same-cycle writes.
   task automatic rd(input int k, input int a);
      logic [31:0] e;
      rd_en[k] = 1'b1;
      rd_addr[k*4 +: 4] = a[3:0];
      if (a == 15) e = pc_in + 32'd8;
      else         e = mdl[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 15) begin
         if (wr0_en && wr0_addr == a[3:0]) e = wr0_data;
         if (wr1_en && wr1_addr == a[3:0]) e = wr1_data;
      end
`endif
      exp_q.push_back(e);
      port_q.push_back(k);
   endtask

   task automatic step();
      int          k;
      logic [31:0] e;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         k = port_q.pop_front();
         e = exp_q.pop_front();
         check($sformatf("rd%0d", k), rd_data[k*32 +: 32], e);
         last_rd[k] = e;
      end
      clear_inputs();
   endtask

   task automatic read_all();
      for (int i = 0; i < 15; i += 3) begin
         for (int k = 0; k < 3; k++) rd(k, i + k);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

   initial begin
      int          n;
      logic [31:0] prev;
      rst = 1'b1;
      clear_inputs();
      rd_addr = '0; wr0_addr = '0; wr1_addr = '0;
      wr0_data = '0; wr1_data = '0; pc_in = '0;
      for (int i = 0; i < 15; i++) mdl[i] = '0;
      for (int k = 0; k < 3; k++) last_rd[k] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) check("rst_rd", rd_data[k*32 +: 32], 32'h0);
      check("rst_pcv", {31'b0, pc_wr_valid}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_conf", {31'b0, wr_conflict}, 32'h0);
      read_all();

      // Fill R0..R14, two distinct addresses per cycle.
      for (int i = 0; i < 15; i += 2) begin
         wr(0, i, 32'h1000_0001 + i * 32'h0101);
         if (i + 1 < 15) wr(1, i + 1, 32'h2000_0001 + (i + 1) * 32'h0101);
         step();
         mdl[i] = 32'h1000_0001 + i * 32'h0101;
         if (i + 1 < 15) mdl[i+1] = 32'h2000_0001 + (i + 1) * 32'h0101;
      end
      read_all();

      pc_in = 32'h0000_0100;
      rd(0, 15);
      step();
      pc_in = 32'hFFFF_FFFC;
      rd(2, 15); rd(1, 4);
      step();

      wr(0, 3, 32'hAAAA); wr(1, 3, 32'h5555);
      step();
      check("conflict", {31'b0, wr_conflict}, 32'h1);
      check("conf_pcv", {31'b0, pc_wr_valid}, 32'h0);
      mdl[3] = 32'h5555;
      rd(0, 3);
      step();
      check("conf_pulse", {31'b0, wr_conflict}, 32'h0);

      wr(0, 15, 32'h2000);
      step();
      check("pcv", {31'b0, pc_wr_valid}, 32'h1);
      check("pc_data", pc_wr_data, 32'h2000);
      rd(1, 3); rd(2, 14);
      step();
      check("pcv_pulse", {31'b0, pc_wr_valid}, 32'h0);

      wr(0, 15, 32'h3000); wr(1, 15, 32'h4000);
      step();
      check("pc_both_v", {31'b0, pc_wr_valid}, 32'h1);
      check("pc_both_d", pc_wr_data, 32'h4000);
      check("pc_both_c", {31'b0, wr_conflict}, 32'h1);

      prev = mdl[5];
      wr(0, 5, 32'h1234);
      rd(0, 5);
      step();
      mdl[5] = 32'h1234;
      rd(0, 5);
      step();
      if (prev == 32'h1234) $display("note: R5 preload equals bypass value");

      wr(1, 5, 32'hBEEF);
      step();
      mdl[5] = 32'hBEEF;
      check("rd_hold", rd_data[31:0], last_rd[0]);

      clr_req = 1'b1;
      step();
      check("clr_busy", {31'b0, busy}, 32'h1);
      n = 1;
      for (int c = 0; c < 40 && busy; c++) begin
         if (c == 2) clr_req = 1'b1;
         if (c == 6) wr(1, 2, 32'h77);
         if (c == 3) wr(0, 15, 32'hDEAD);
         step();
         if (c == 3) check("clr_pcv", {31'b0, pc_wr_valid}, 32'h0);
         if (busy) n++;
      end
      check("busy_len", n, 32'd15);
      for (int i = 0; i < 15; i++) mdl[i] = '0;
      read_all();

      wr(0, 12, 32'h99); wr(1, 1, 32'h55);
      step();
      clr_req = 1'b1;
      step();
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("rst_clr_busy", {31'b0, busy}, 32'h0);
      check("rst_clr_rd", rd_data[31:0], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("rst_clr_idle", {31'b0, busy}, 32'h0);
      read_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
